// File: rtl/fifo_burst_reader.sv
// Drains the shared FIFO in one burst once it reports full, stopping on empty or the burst cap.
// Latency: rdreq to dout_valid is 2 cycles. No downstream backpressure; rdreq is gated by rdempty, so the FIFO never underflows.
module fifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdfull,
    input  logic              rdempty,
    input  logic [DATA_W-1:0] rd_q,
    output logic              rdreq,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              burst_done,
    output logic [CNT_W-1:0]  burst_len,
    output logic              seq_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_FLUSH1 = 2'd2,
        S_FLUSH2 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_count;
    logic                r_rd_pend;
    logic                r_first;
    logic [DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]   r_expect;
    logic                r_dout_valid;
    logic                r_burst_done;
    logic [CNT_W-1:0]    r_burst_len;
    logic                r_seq_err;
    logic                w_cap_hit;
    logic                w_rdreq;
    logic [DATA_W-1:0]   w_expect_nxt;

    assign w_cap_hit    = (MAX_BURST != 0) && (r_count == CAP);
    assign w_expect_nxt = rd_q + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_rdreq     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Full and empty together is treated as empty: nothing to drain.
                if (rdfull && !rdempty) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (rdempty || w_cap_hit) begin
                    w_state_nxt = S_FLUSH1;
                end else begin
                    w_rdreq = !rst;
                end
            end
            S_FLUSH1: w_state_nxt = S_FLUSH2;
            S_FLUSH2: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_rd_pend    <= 1'b0;
            r_first      <= 1'b1;
            r_dout       <= '0;
            r_expect     <= '0;
            r_dout_valid <= 1'b0;
            r_burst_done <= 1'b0;
            r_burst_len  <= '0;
            r_seq_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_pend    <= w_rdreq;
            r_dout_valid <= r_rd_pend;
            r_burst_done <= (r_state == S_FLUSH1);
            if (r_state == S_IDLE) begin
                r_count <= '0;
            end else if (w_rdreq && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
            if (r_state == S_FLUSH1) begin
                r_burst_len <= r_count;
            end
            // Continuity is judged as the word is captured so seq_err lines up with its dout_valid.
            if (r_rd_pend) begin
                r_dout   <= rd_q;
                r_expect <= w_expect_nxt;
                r_first  <= 1'b0;
                if (!r_first && (rd_q != r_expect)) begin
                    r_seq_err <= 1'b1;
                end
            end
        end
    end

    assign rdreq      = w_rdreq;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign burst_done = r_burst_done;
    assign burst_len  = r_burst_len;
    assign seq_err    = r_seq_err;

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for the shared single-clock FIFO. The write-side controller fills the FIFO with an incrementing byte stream. This block waits for the FIFO to report full, then drains it in one burst until empty or until a programmable burst cap is reached. It presents each word as a registered output with a valid strobe, checks stream continuity, and reports the burst length. It sits between the FIFO's read port and downstream consumers or the test display.

Parameters:
DATA_W, 8, width of FIFO read data and dout.
MAX_BURST, 0, maximum words per burst; 0 = unlimited (drain until empty). Legal range 0..65535.
CNT_W, 16, width of the burst length counter.

Ports:
clk  in  1  system clock, shared by FIFO read and write sides.
rst  in  1  synchronous, active-high reset.
rdfull  in  1  FIFO read-side full flag.
rdempty  in  1  FIFO read-side empty flag.
rd_q  in  DATA_W  FIFO read data; normal (non-show-ahead) mode, valid 1 cycle after rdreq.
rdreq  out  1  FIFO read request (combinational).
dout  out  DATA_W  registered read word.
dout_valid  out  1  one-cycle strobe; dout holds a new word.
burst_done  out  1  one-cycle pulse at end of each burst.
burst_len  out  CNT_W  words read in the last completed burst; updated together with burst_done.
seq_err  out  1  sticky flag: a stream discontinuity was detected.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All flops clear on the rising clk edge while rst=1.
- Reset values: state=IDLE, rdreq=0, dout=0, dout_valid=0, burst_done=0, burst_len=0, seq_err=0, internal word count=0, first-word flag=1.
- rdreq = (state==READ) & ~rdempty & ~rst & ~cap_hit.
  - cap_hit = (MAX_BURST!=0) & (count==MAX_BURST).
  - rdreq is never asserted while rdempty=1, so the FIFO can never underflow.
- Read pipeline:
  - Cycle N: rdreq=1.
  - Cycle N+1: rd_q is valid, and rd_q is registered into dout at the end of this cycle.
  - Cycle N+2: dout_valid=1 with the new dout.
  - Read-request-to-output latency is therefore 2 cycles.
  - Back-to-back rdreq gives one dout_valid per cycle, with no bubbles.
- FSM:
  - IDLE: count cleared. IDLE -> READ when rdfull=1.
  - READ: count increments on every cycle with rdreq=1; the counter saturates at all-ones. READ -> FLUSH when rdempty=1 or cap_hit=1 (no rdreq issued that cycle).
  - FLUSH: lasts 2 cycles so the last word reaches dout. FLUSH -> IDLE after the second cycle.
  - burst_done pulses in the final FLUSH cycle. burst_len <= count in that same cycle.
- Re-entry: IDLE re-enters READ only on a new rdfull=1. A partially drained FIFO left by a MAX_BURST cap is not read until it is full again.
- Continuity check, evaluated on each dout_valid word:
  - First word after reset: load expected <= word+1; no check is made.
  - Later words: if word != expected, set seq_err (sticky until rst).
  - In both cases expected <= word+1, modulo 2^DATA_W, so 8'hFF is followed by 8'h00.
  - The check carries across bursts.
- Simultaneous events:
  - rdfull and rdempty both high: treated as empty; no rdreq is issued.
  - rdfull rising while in READ or FLUSH: ignored.
- Reset mid-burst: rdreq drops in the same cycle rst is high (combinational gate). Words in flight are discarded, with no dout_valid after reset. The FSM returns to IDLE.

Test Plan:
- Writer fills 16-deep FIFO with 0x00..0x0F, MAX_BURST=0:
  - rdreq high for exactly 16 cycles.
  - dout_valid for 16 consecutive cycles, 2 cycles later, with dout 0x00..0x0F.
  - burst_done pulse with burst_len=16; seq_err=0.
- MAX_BURST=5, full 16-deep FIFO:
  - exactly 5 words read; burst_len=5.
  - no further rdreq until rdfull rises again.
- Stream wrap across bursts, data 0xF8..0xFF then 0x00..0x07: seq_err stays 0.
- Inject 0x03 followed by 0x05 in the stream: seq_err=1 two cycles after the 0x05 rdreq and stays high; later continuous data does not clear it.
- Assert rst for 1 cycle midway through a 16-word burst:
  - rdreq=0 in the reset cycle.
  - no dout_valid afterwards; all outputs at reset values.
  - state IDLE until the next rdfull.
- Hold rdempty=1 with rdfull=0 for 100 cycles: rdreq stays 0 and dout_valid stays 0.
